// File: rtl/multi_counter_v2.sv
// multi_counter_v2 -- table of CNTRS_N independent CNTRS_W-bit counters.
//
// Counters live in a simple dual-port RAM: port 1 reads, port 2 writes.
// Commands move through a 4-stage read-modify-write pipeline at one command
// per cycle:
//   S1 registers the command,
//   S2 reads the RAM,
//   S3 executes,
//   S4 writes back and drives status.
// A command accepted at edge t retires on the status outputs at edge t+4.
// After reset, a sweep FSM writes zero to every entry. It holds cntr_busy_r
// high while it runs, and commands presented during that time are dropped.
//
// Optional build macro: MULTI_COUNTER_V2_SAT_EN
//   defined   -> INCR/ADD saturate at all-ones, DECR/SUB saturate at zero,
//                and status_ovf_r flags that clamping occurred.
//   undefined -> modulo 2^CNTRS_W arithmetic, and status_ovf_r is the raw
//                carry/borrow.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   cntr_pass      command valid
//   cntr_id        target counter
//   cntr_op        0 NOP, 1 INIT, 2 INCR, 3 DECR, 4 ADD, 5 SUB, 6 QRY, 7 QRY_CLR
//   cntr_dat       INIT value, or ADD/SUB operand
//   cntr_busy_r    sweep in progress; commands are not accepted
//   status_pass_r  a command retired this cycle
//   status_qry_r   the retired command was QRY or QRY_CLR
//   status_id_r    id of the retired command
//   status_dat_r   result value (for QRY_CLR, the value before clearing)
//   status_ovf_r   carry/borrow (or clamp) of a retired INCR/DECR/ADD/SUB
module multi_counter_v2 #(
  parameter int CNTRS_N = 256,
  parameter int CNTRS_W = 32,
  localparam int CNTRS_ID_W = $clog2(CNTRS_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cntr_pass,
  input  logic [CNTRS_ID_W-1:0] cntr_id,
  input  logic [2:0]            cntr_op,
  input  logic [CNTRS_W-1:0]    cntr_dat,
  output logic                  cntr_busy_r,
  output logic                  status_pass_r,
  output logic                  status_qry_r,
  output logic [CNTRS_ID_W-1:0] status_id_r,
  output logic [CNTRS_W-1:0]    status_dat_r,
  output logic                  status_ovf_r
);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_INIT    = 3'd1;
  localparam logic [2:0] OP_INCR    = 3'd2;
  localparam logic [2:0] OP_DECR    = 3'd3;
  localparam logic [2:0] OP_ADD     = 3'd4;
  localparam logic [2:0] OP_SUB     = 3'd5;
  localparam logic [2:0] OP_QRY     = 3'd6;
  localparam logic [2:0] OP_QRY_CLR = 3'd7;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_SWEEP, ST_IDLE} sweep_state_t;

  sweep_state_t          state_reg, state_next;
  logic [CNTRS_ID_W-1:0] ptr_reg, ptr_next;
  logic                  sweep_wr;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sweep_wr   = 1'b0;
    if (state_reg == ST_SWEEP) begin
      sweep_wr = 1'b1;
      ptr_next = ptr_reg + CNTRS_ID_W'(1);
      if (ptr_reg == CNTRS_ID_W'(CNTRS_N - 1)) begin
        state_next = ST_IDLE;
        ptr_next   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_SWEEP;
      ptr_reg     <= '0;
      cntr_busy_r <= 1'b1;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cntr_busy_r <= (state_next == ST_SWEEP);
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic accept;
  assign accept = cntr_pass && (cntr_op != OP_NOP) && !cntr_busy_r;

  logic                  s1_valid_reg, s2_valid_reg, s3_valid_reg, s4_valid_reg;
  logic [CNTRS_ID_W-1:0] s1_id_reg, s2_id_reg, s3_id_reg, s4_id_reg;
  logic [2:0]            s1_op_reg, s2_op_reg, s3_op_reg;
  logic [CNTRS_W-1:0]    s1_dat_reg, s2_dat_reg, s3_dat_reg;
  logic [CNTRS_W-1:0]    s3_v_reg;
  logic                  s4_wr_reg, s4_qry_reg, s4_ovf_reg;
  logic [CNTRS_W-1:0]    s4_new_reg, s4_stat_reg;

  // ---------------------------------------------------------------------------
  // Counter RAM
  // ---------------------------------------------------------------------------
  logic [CNTRS_W-1:0]    mem [CNTRS_N];
  logic [CNTRS_W-1:0]    rd_dat_reg;
  logic                  s2_byp_reg;
  logic [CNTRS_W-1:0]    s2_byp_dat_reg;
  logic                  mem_we;
  logic [CNTRS_ID_W-1:0] mem_waddr;
  logic [CNTRS_W-1:0]    mem_wdata;
  logic                  s1_byp_hit;

  // The sweep and the S4 writeback never overlap, because nothing is
  // accepted while the sweep runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s4_id_reg;
    mem_wdata = s4_new_reg;
    if (!rst) begin
      if (sweep_wr) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_reg;
        mem_wdata = '0;
      end else if (s4_valid_reg && s4_wr_reg) begin
        mem_we = 1'b1;
      end
    end
  end

  // If S4 writes the entry that S1 is reading at the same edge, the RAM would
  // return the stale value. Capture the write data alongside the read and
  // select it in S2. The mux sits after the RAM output register so the array
  // still maps onto block RAM.
  assign s1_byp_hit = s4_valid_reg && s4_wr_reg && (s4_id_reg == s1_id_reg);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_dat_reg     <= mem[s1_id_reg];
    s2_byp_reg     <= s1_byp_hit;
    s2_byp_dat_reg <= s4_new_reg;
  end

  // ---------------------------------------------------------------------------
  // S3 execute
  // ---------------------------------------------------------------------------
  logic [CNTRS_W-1:0] ex_opnd, ex_new, ex_stat;
  logic [CNTRS_W:0]   ex_sum, ex_diff;
  logic               ex_wr, ex_qry, ex_ovf;

  always_comb begin
    if ((s3_op_reg == OP_INCR) || (s3_op_reg == OP_DECR)) begin
      ex_opnd = CNTRS_W'(1);
    end else begin
      ex_opnd = s3_dat_reg;
    end

    ex_sum  = {1'b0, s3_v_reg} + {1'b0, ex_opnd};
    ex_diff = {1'b0, s3_v_reg} - {1'b0, ex_opnd};

    ex_new  = s3_v_reg;
    ex_stat = s3_v_reg;
    ex_wr   = 1'b0;
    ex_qry  = 1'b0;
    ex_ovf  = 1'b0;

    case (s3_op_reg)
      OP_INIT: begin
        ex_new  = s3_dat_reg;
        ex_stat = s3_dat_reg;
        ex_wr   = 1'b1;
      end

      OP_INCR, OP_ADD: begin
        ex_ovf = ex_sum[CNTRS_W];
`ifdef MULTI_COUNTER_V2_SAT_EN
        ex_new = ex_sum[CNTRS_W] ? {CNTRS_W{1'b1}} : ex_sum[CNTRS_W-1:0];
`else
        ex_new = ex_sum[CNTRS_W-1:0];
`endif
        ex_stat = ex_new;
        ex_wr   = 1'b1;
      end

      OP_DECR, OP_SUB: begin
        ex_ovf = ex_diff[CNTRS_W];
`ifdef MULTI_COUNTER_V2_SAT_EN
        ex_new = ex_diff[CNTRS_W] ? '0 : ex_diff[CNTRS_W-1:0];
`else
        ex_new = ex_diff[CNTRS_W-1:0];
`endif
        ex_stat = ex_new;
        ex_wr   = 1'b1;
      end

      OP_QRY: begin
        ex_qry = 1'b1;
      end

      OP_QRY_CLR: begin
        ex_new = '0;
        ex_wr  = 1'b1;
        ex_qry = 1'b1;
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // S2 forwarding
  // ---------------------------------------------------------------------------
  // The value handed to S3 must reflect every older in-flight write to the
  // same id. The op one stage ahead (S3) is the youngest of those, so it wins
  // over S4, which in turn wins over the RAM read. QRY is skipped because it
  // does not change the value. INIT discards v in execute, so forwarding into
  // it is harmless.
  logic [CNTRS_W-1:0] s2_mem_v, fwd_v;

  always_comb begin
    s2_mem_v = s2_byp_reg ? s2_byp_dat_reg : rd_dat_reg;
    if (s3_valid_reg && ex_wr && (s3_id_reg == s2_id_reg)) begin
      fwd_v = ex_new;
    end else if (s4_valid_reg && s4_wr_reg && (s4_id_reg == s2_id_reg)) begin
      fwd_v = s4_new_reg;
    end else begin
      fwd_v = s2_mem_v;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  // Valids and status take reset, so a reset drops every in-flight command
  // without producing status for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s3_valid_reg  <= 1'b0;
      s4_valid_reg  <= 1'b0;
      status_pass_r <= 1'b0;
      status_qry_r  <= 1'b0;
      status_ovf_r  <= 1'b0;
      status_id_r   <= '0;
      status_dat_r  <= '0;
    end else begin
      s1_valid_reg  <= accept;
      s2_valid_reg  <= s1_valid_reg;
      s3_valid_reg  <= s2_valid_reg;
      s4_valid_reg  <= s3_valid_reg;
      status_pass_r <= s4_valid_reg;
      status_qry_r  <= s4_valid_reg && s4_qry_reg;
      status_ovf_r  <= s4_valid_reg && s4_ovf_reg;
      if (s4_valid_reg) begin
        status_id_r  <= s4_id_reg;
        status_dat_r <= s4_stat_reg;
      end
    end
  end

  // Payload registers carry no reset; they are qualified by the valids.
  always_ff @(posedge clk) begin
    s1_id_reg   <= cntr_id;
    s1_op_reg   <= cntr_op;
    s1_dat_reg  <= cntr_dat;

    s2_id_reg   <= s1_id_reg;
    s2_op_reg   <= s1_op_reg;
    s2_dat_reg  <= s1_dat_reg;

    s3_id_reg   <= s2_id_reg;
    s3_op_reg   <= s2_op_reg;
    s3_dat_reg  <= s2_dat_reg;
    s3_v_reg    <= fwd_v;

    s4_id_reg   <= s3_id_reg;
    s4_wr_reg   <= ex_wr;
    s4_qry_reg  <= ex_qry;
    s4_ovf_reg  <= ex_ovf;
    s4_new_reg  <= ex_new;
    s4_stat_reg <= ex_stat;
  end

endmodule

// File: doc/multi_counter_v2.md
Name: multi_counter_v2

Overview:
Parametrised next-generation counter table: CNTRS_N independent CNTRS_W-bit counters held in a dpsram and updated by a 4-stage read-modify-write pipeline, one command per cycle. It adds arithmetic ops (ADD/SUB by operand) and read-and-clear, plus per-result overflow reporting. A post-reset sweep FSM zeroes the whole table and back-pressures the command interface while it runs. It sits behind a command issuer and drives a status/telemetry consumer.

Parameters:
CNTRS_N, 256, number of counters (>=2)
CNTRS_W, 32, counter and operand width in bits
CNTRS_ID_W, $clog2(CNTRS_N), counter index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cntr_pass  in  1  command valid
cntr_id  in  CNTRS_ID_W  target counter
cntr_op  in  3  opcode: 0 NOP, 1 INIT, 2 INCR, 3 DECR, 4 ADD, 5 SUB, 6 QRY, 7 QRY_CLR
cntr_dat  in  CNTRS_W  INIT value / ADD-SUB operand
cntr_busy_r  out  1  table sweep in progress; commands not accepted
status_pass_r  out  1  a non-NOP command retired this cycle
status_qry_r  out  1  retired command was QRY or QRY_CLR
status_id_r  out  CNTRS_ID_W  id of retired command
status_dat_r  out  CNTRS_W  result value
status_ovf_r  out  1  retired INCR/ADD carried out or DECR/SUB borrowed

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: cntr_busy_r=1; status_pass_r, status_qry_r and status_ovf_r=0; status_id_r and status_dat_r=0; all pipeline valids=0.
- Acceptance: a command is accepted when cntr_pass=1, cntr_op!=NOP and cntr_busy_r=0. Commands presented while busy are dropped silently and must not reach the table.
- Latency: a command accepted at clock edge t retires on status at edge t+4. Throughput is one command per cycle with no bubbles.
- Pipeline stages:
  - S1: register the command.
  - S2: memory read on port 1.
  - S3: execute.
  - S4: write back on port 2 and drive status.
- Op semantics, with v = current value:
  - INIT: v'=dat.
  - INCR: v+1.
  - DECR: v-1.
  - ADD: v+dat.
  - SUB: v-dat.
  - QRY: v'=v, no write.
  - QRY_CLR: v'=0.
- Status data: status_dat_r=v' for all ops except QRY_CLR, which reports the old v.
- Arithmetic: modulo 2^CNTRS_W (see optional feature). status_ovf_r is the carry/borrow out of the CNTRS_W-bit operation and is 0 for INIT, QRY and QRY_CLR.
- Hazards: every op must observe the result of all older in-flight ops to the same id. Forward S4->S2, S3->S2 and S4->S3 with the youngest-older value taking priority.
  - Same-cycle S1 read vs S4 write to the same id: suppress the read and take the write data.
  - INIT ignores forwarding.
  - Back-to-back same-id traffic must be bit-exact with a sequential model.
- Sweep FSM (SWEEP, IDLE):
  - rst forces SWEEP with ptr=0.
  - In SWEEP, each cycle after rst deasserts writes 0 to entry ptr on port 2, then ptr++.
  - After writing entry CNTRS_N-1, transition to IDLE. cntr_busy_r drops on the next edge, CNTRS_N cycles after rst falls.
  - rst asserted mid-sweep or mid-operation restarts the sweep at 0 and discards in-flight commands, producing no status for them.
- Port 2 ownership: the sweep and S4 writeback never overlap, because nothing is accepted while busy.

Optional Feature:
MULTI_COUNTER_V2_SAT_EN
- Defined: INCR/ADD clamp at all-ones and DECR/SUB clamp at 0. status_ovf_r=1 whenever clamping occurred; the stored value is the clamped value.
- Undefined: modulo wrap as above, with status_ovf_r reporting the raw carry/borrow.
- Latency and hazard behaviour are identical in both builds.

Test Plan:
- Reset sweep, CNTRS_N=16: pulse rst for 2 cycles. cntr_busy_r stays 1 for 16 cycles after rst falls. A cntr_pass issued during busy is dropped. A subsequent QRY of every id returns 0.
- Latency: INIT id3 dat=0x10 at edge t, then QRY id3. Edge t+4 gives status_pass_r=1, status_qry_r=0, dat=0x10. Edge t+5 gives status_qry_r=1, dat=0x10.
- Back-to-back hazard: INIT id5 0, INCR id5, ADD id5 7, DECR id5, QRY id5 on consecutive cycles. Status data sequence is 0, 1, 8, 7, 7. Repeat with 1-cycle and 2-cycle gaps; same values.
- Read-and-clear: id2=0x55, then QRY_CLR id2 then QRY id2. Results 0x55 then 0.
- Overflow, wrap build: INIT id1 0xFFFFFFFF, INCR id1 -> dat=0, ovf=1. SUB id1 dat=1 -> dat=0xFFFFFFFF, ovf=1.
- Saturate build with MULTI_COUNTER_V2_SAT_EN: same stimulus gives 0xFFFFFFFF with ovf=1, then 0xFFFFFFFE with ovf=0. Reset asserted mid-stream with 3 ops in flight produces no status for them and restarts the sweep.
